// File: rtl/button_conditioner.sv
// Three-channel push-button front end for the stopwatch: two-flop synchronizer,
// symmetric debounce, and registered press / release / hold pulses per channel.
module button_conditioner #(
    parameter int unsigned DEBOUNCE_CYCLES = 10000,
    parameter int unsigned HOLD_CYCLES     = 1000000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [2:0] i_btn,
    output logic [2:0] o_level,
    output logic [2:0] o_press,
    output logic [2:0] o_release,
    output logic [2:0] o_hold
);

    localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int HD_W = $clog2(HOLD_CYCLES + 1);

    // The sample that leaves IDLE/HELD is the first of the run, so the wait
    // states only need DEBOUNCE_CYCLES-1 more agreeing samples.
    localparam bit              DB_SINGLE = (DEBOUNCE_CYCLES <= 1);
    localparam int unsigned     DB_LAST_I = (DEBOUNCE_CYCLES >= 2) ? DEBOUNCE_CYCLES - 2 : 0;
    localparam logic [DB_W-1:0] DB_LAST   = DB_W'(DB_LAST_I);
    localparam logic [HD_W-1:0] HOLD_MAX  = HD_W'(HOLD_CYCLES);
    localparam logic [HD_W-1:0] HOLD_LAST = HD_W'(HOLD_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE,
        PRESS_WAIT,
        HELD,
        RELEASE_WAIT
    } state_e;

    logic [2:0] sync1_q;
    logic [2:0] sync2_q;

    // NOTE: clocked state uses non-blocking assignments so every flop samples
    // pre-edge values; blocking here would collapse the synchronizer to one stage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= i_btn;
            sync2_q <= sync1_q;
        end
    end

    for (genvar ch = 0; ch < 3; ch++) begin : g_chan
        state_e          state_q, state_d;
        logic [DB_W-1:0] db_cnt_q, db_cnt_d;
        logic [HD_W-1:0] hold_cnt_q, hold_cnt_d;
        logic            level_q, level_d;
        logic            press_q, press_d;
        logic            release_q, release_d;
        logic            hold_q, hold_d;
        logic            s;

        assign s = sync2_q[ch];

        // NOTE: every variable gets a default before the case so no path
        // leaves one unassigned, which would otherwise infer a latch.
        always_comb begin
            state_d    = state_q;
            db_cnt_d   = db_cnt_q;
            hold_cnt_d = hold_cnt_q;
            press_d    = 1'b0;
            release_d  = 1'b0;
            hold_d     = 1'b0;

            unique case (state_q)
                IDLE: begin
                    if (s) begin
                        db_cnt_d = '0;
                        if (DB_SINGLE) begin
                            state_d    = HELD;
                            press_d    = 1'b1;
                            hold_cnt_d = '0;
                        end else begin
                            state_d = PRESS_WAIT;
                        end
                    end
                end

                PRESS_WAIT: begin
                    if (!s) begin
                        state_d  = IDLE;
                        db_cnt_d = '0;
                    end else if (db_cnt_q == DB_LAST) begin
                        state_d    = HELD;
                        db_cnt_d   = '0;
                        press_d    = 1'b1;
                        hold_cnt_d = '0;
                    end else begin
                        db_cnt_d = db_cnt_q + 1'b1;
                    end
                end

                HELD: begin
                    if (!s) begin
                        db_cnt_d = '0;
                        if (DB_SINGLE) begin
                            state_d    = IDLE;
                            release_d  = 1'b1;
                            hold_cnt_d = '0;
                        end else begin
                            state_d = RELEASE_WAIT;
                        end
                    end else if (hold_cnt_q != HOLD_MAX) begin
                        // Saturating count: the crossing fires once per press.
                        hold_cnt_d = hold_cnt_q + 1'b1;
                        hold_d     = (hold_cnt_q == HOLD_LAST);
                    end
                end

                RELEASE_WAIT: begin
                    if (s) begin
                        state_d  = HELD;
                        db_cnt_d = '0;
                    end else if (db_cnt_q == DB_LAST) begin
                        state_d    = IDLE;
                        db_cnt_d   = '0;
                        hold_cnt_d = '0;
                        release_d  = 1'b1;
                    end else begin
                        db_cnt_d = db_cnt_q + 1'b1;
                    end
                end

                default: begin
                    state_d    = IDLE;
                    db_cnt_d   = '0;
                    hold_cnt_d = '0;
                end
            endcase

            level_d = (state_d == HELD) || (state_d == RELEASE_WAIT);
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                state_q    <= IDLE;
                db_cnt_q   <= '0;
                hold_cnt_q <= '0;
                level_q    <= 1'b0;
                press_q    <= 1'b0;
                release_q  <= 1'b0;
                hold_q     <= 1'b0;
            end else begin
                state_q    <= state_d;
                db_cnt_q   <= db_cnt_d;
                hold_cnt_q <= hold_cnt_d;
                level_q    <= level_d;
                press_q    <= press_d;
                release_q  <= release_d;
                hold_q     <= hold_d;
            end
        end

        assign o_level[ch]   = level_q;
        assign o_press[ch]   = press_q;
        assign o_release[ch] = release_q;
        assign o_hold[ch]    = hold_q;
    end

endmodule

// File: tb/tb_button_conditioner.sv
// Bench for button_conditioner: directed edge-exact scenarios plus randomized
// button activity, all checked against a rule-level model through a scoreboard.
module tb_button_conditioner;

    localparam int D = 4;
    localparam int H = 20;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [2:0] i_btn;
    logic [2:0] o_level, o_press, o_release, o_hold;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct packed {
        logic [2:0] level;
        logic [2:0] press;
        logic [2:0] rel;
        logic [2:0] hold;
    } exp_t;

    exp_t exp_q[$];

    button_conditioner #(
        .DEBOUNCE_CYCLES(D),
        .HOLD_CYCLES    (H)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_btn    (i_btn),
        .o_level  (o_level),
        .o_press  (o_press),
        .o_release(o_release),
        .o_hold   (o_hold)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        n_checks++;
        if (act !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp_v);
        end
    endtask

    // Reference model: the accepted level flips after D consecutive
    // synchronized samples that disagree with it; hold time counts cycles in
    // which the accepted-high button was seen high on two consecutive samples.
    logic [2:0] m_p1, m_p2, m_prev_s, m_level;
    int         m_run[3];
    int         m_hold[3];

    task automatic model_step();
        exp_t       e;
        logic [2:0] s;
        e = '0;
        if (!rst_n) begin
            m_p1 = '0; m_p2 = '0; m_prev_s = '0; m_level = '0;
            for (int c = 0; c < 3; c++) begin
                m_run[c]  = 0;
                m_hold[c] = 0;
            end
        end else begin
            s    = m_p2;
            m_p2 = m_p1;
            m_p1 = i_btn;
            for (int c = 0; c < 3; c++) begin
                m_run[c] = (s[c] != m_level[c]) ? m_run[c] + 1 : 0;
                if (m_run[c] == D) begin
                    m_run[c]   = 0;
                    m_level[c] = s[c];
                    m_hold[c]  = 0;
                    if (s[c]) e.press[c] = 1'b1;
                    else      e.rel[c]   = 1'b1;
                end else if (m_level[c] && m_prev_s[c] && s[c] && m_hold[c] < H) begin
                    m_hold[c]++;
                    if (m_hold[c] == H) e.hold[c] = 1'b1;
                end
                m_prev_s[c] = s[c];
            end
            e.level = m_level;
        end
        exp_q.push_back(e);
    endtask

    initial begin
        forever begin
            @(posedge clk);
            model_step();
        end
    end

    // Monitor: one registered output word per edge, compared against the queue.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL scoreboard: DUT output present but no expected entry queued");
            end else begin
                e = exp_q.pop_front();
                check("scoreboard outputs", {o_level, o_press, o_release, o_hold}, e);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic expect_step(input string name, input int k, input logic [2:0] mask,
                               input logic [2:0] lvl, input logic [2:0] prs,
                               input logic [2:0] rel, input logic [2:0] hld);
        tick();
        check($sformatf("%s k=%0d", name, k),
              {o_level & mask, o_press & mask, o_release & mask, o_hold & mask},
              {lvl & mask, prs & mask, rel & mask, hld & mask});
    endtask

    task automatic idle_wait(input int n);
        for (int k = 1; k <= n; k++) expect_step("idle", k, 3'b111, '0, '0, '0, '0);
    endtask

    initial begin
        int         rem[3];
        logic [2:0] b;
        logic [6:0] bounce;

        rst_n = 1'b0;
        i_btn = '0;
        #1;
        check("reset state", {o_level, o_press, o_release, o_hold}, '0);
        repeat (3) tick();
        rst_n = 1'b1;
        idle_wait(4);

        // Clean press on channel 0, hold pulse 20 cycles after the press.
        i_btn = 3'b001;
        for (int k = 1; k <= 30; k++)
            expect_step("clean press", k, 3'b111, (k >= 6) ? 3'b001 : 3'b000,
                        (k == 6) ? 3'b001 : 3'b000, 3'b000, (k == 26) ? 3'b001 : 3'b000);
        i_btn = 3'b000;
        for (int k = 1; k <= 10; k++)
            expect_step("clean release", k, 3'b111, (k < 6) ? 3'b001 : 3'b000,
                        3'b000, (k == 6) ? 3'b001 : 3'b000, 3'b000);

        // Bounce rejection on channel 1.
        bounce = 7'b1110111;
        for (int k = 0; k < 18; k++) begin
            i_btn[1] = (k < 7) ? bounce[6-k] : 1'b0;
            expect_step("bounce reject", k, 3'b010, '0, '0, '0, '0);
        end

        // Release glitch on held channel 2.
        i_btn = 3'b100;
        for (int k = 1; k <= 8; k++)
            expect_step("glitch press", k, 3'b100, (k >= 6) ? 3'b100 : 3'b000,
                        (k == 6) ? 3'b100 : 3'b000, '0, '0);
        i_btn = 3'b000;
        for (int k = 1; k <= 2; k++) expect_step("glitch low", k, 3'b100, 3'b100, '0, '0, '0);
        i_btn = 3'b100;
        for (int k = 1; k <= 8; k++) expect_step("glitch recover", k, 3'b100, 3'b100, '0, '0, '0);
        i_btn = 3'b000;
        for (int k = 1; k <= 10; k++)
            expect_step("glitch release", k, 3'b100, (k < 6) ? 3'b100 : 3'b000,
                        '0, (k == 6) ? 3'b100 : 3'b000, '0);

        // Simultaneous press and release on all channels.
        i_btn = 3'b111;
        for (int k = 1; k <= 10; k++)
            expect_step("simul press", k, 3'b111, (k >= 6) ? 3'b111 : 3'b000,
                        (k == 6) ? 3'b111 : 3'b000, '0, '0);
        i_btn = 3'b000;
        for (int k = 1; k <= 10; k++)
            expect_step("simul release", k, 3'b111, (k < 6) ? 3'b111 : 3'b000,
                        '0, (k == 6) ? 3'b111 : 3'b000, '0);

        // Reset while channel 0 is held: no release, fresh press afterwards.
        i_btn = 3'b001;
        for (int k = 1; k <= 10; k++)
            expect_step("pre-reset press", k, 3'b111, (k >= 6) ? 3'b001 : 3'b000,
                        (k == 6) ? 3'b001 : 3'b000, '0, '0);
        rst_n = 1'b0;
        #1;
        check("reset immediate", {o_level, o_press, o_release, o_hold}, '0);
        for (int k = 1; k <= 2; k++) expect_step("in reset", k, 3'b111, '0, '0, '0, '0);
        rst_n = 1'b1;
        for (int k = 1; k <= 10; k++)
            expect_step("post-reset press", k, 3'b111, (k >= 6) ? 3'b001 : 3'b000,
                        (k == 6) ? 3'b001 : 3'b000, '0, '0);
        i_btn = 3'b000;
        for (int k = 1; k <= 10; k++)
            expect_step("post-reset release", k, 3'b111, (k < 6) ? 3'b001 : 3'b000,
                        '0, (k == 6) ? 3'b001 : 3'b000, '0);

        // Randomized activity: mix of bounce-length and hold-length runs,
        // with occasional short resets; checked by the scoreboard alone.
        for (int c = 0; c < 3; c++) rem[c] = $urandom_range(1, 10);
        for (int n = 0; n < 4000; n++) begin
            b = i_btn;
            for (int c = 0; c < 3; c++) begin
                rem[c]--;
                if (rem[c] == 0) begin
                    b[c]   = ~b[c];
                    rem[c] = ($urandom_range(0, 1) == 1) ? $urandom_range(1, 5)
                                                         : $urandom_range(6, 40);
                end
            end
            i_btn = b;
            if ($urandom_range(0, 499) == 0) begin
                rst_n = 1'b0;
                repeat ($urandom_range(1, 3)) tick();
                rst_n = 1'b1;
            end
            tick();
        end

        i_btn = '0;
        repeat (12) tick();
        check("scoreboard drained", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
